fft_frame_sched: RTL and testbench

Ping-pong frame scheduler between the decimating FIR and the R22SDF FFT. It aligns FIR output samples to chirp boundaries and writes each chirp's FFT_N samples into one half of a two-bank sample RAM. It then sequences the FFT to read each completed bank while the other bank fills. Banks are released when the FFT reports its output frame. Overruns and short chirps are flagged rather than corrupting a frame.

---
 rtl/fft_frame_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// ---------------------------------------------------------------------------
// fft_frame_sched
//
// Ping-pong frame scheduler between the decimating FIR and the R22SDF FFT.
// The write side aligns FIR samples to chirp boundaries and fills one half
// of a two-bank sample RAM with FFT_N samples per chirp. The read side then
// streams each completed bank into the FFT while the other bank fills.
// A bank is released when the FFT reports that it has emitted the frame.
// A chirp that finds no free bank is dropped. A chirp that arrives
// mid-fill restarts the current bank. Both cases raise a one-cycle
// status pulse.
//
// Ports
//   clk_i, rst_i       system clock, synchronous active-high reset
//   enable_i           gates acceptance of new chirps (not restarts)
//   chirp_start_i      one-cycle ramp-start pulse
//   sample_valid_i     FIR output strobe, qualifies sample_i
//   sample_i           FIR output sample
//   wr_en_o            RAM write enable (registered)
//   wr_addr_o          RAM write address {bank, index} (registered)
//   wr_data_o          RAM write data (registered sample_i)
//   fft_start_o        one-cycle pulse ahead of a frame's first read
//   fft_ready_i        FFT can accept a sample this cycle
//   rd_en_o            RAM read enable, one sample per asserted cycle
//   rd_addr_o          RAM read address {bank, index} (registered)
//   fft_done_i         FFT has emitted the frame; releases the bank
//   frame_drop_o       chirp rejected because no bank was free
//   frame_short_o      chirp restarted a partially filled bank
//   frame_ctr_o        count of released frames, wraps
// ---------------------------------------------------------------------------
module fft_frame_sched #(
    parameter int unsigned FFT_N      = 1024,
    parameter int unsigned N_WIDTH    = $clog2(FFT_N),
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned CTR_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  chirp_start_i,
    input  logic                  sample_valid_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    output logic                  wr_en_o,
    output logic [N_WIDTH:0]      wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  fft_start_o,
    input  logic                  fft_ready_i,
    output logic                  rd_en_o,
    output logic [N_WIDTH:0]      rd_addr_o,
    input  logic                  fft_done_i,
    output logic                  frame_drop_o,
    output logic                  frame_short_o,
    output logic [CTR_WIDTH-1:0]  frame_ctr_o
);

    typedef enum logic {W_IDLE, W_FILL} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_START, R_READ, R_WAIT} rstate_e;

    localparam logic [N_WIDTH-1:0] LAST_IDX = N_WIDTH'(FFT_N - 1);

    wstate_e               wstate_q, wstate_d;
    rstate_e               rstate_q, rstate_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [1:0]            full_q, full_d;
    logic [N_WIDTH-1:0]    wr_idx_q, wr_idx_d;
    logic [N_WIDTH-1:0]    rd_idx_q, rd_idx_d;
    logic [CTR_WIDTH-1:0]  ctr_q, ctr_d;
    logic                  wr_en_q, wr_en_d;
    logic [N_WIDTH:0]      wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  drop_q, drop_d;
    logic                  short_q, short_d;

    logic release_w;   // R_WAIT sees fft_done_i: bank rd_bank_q is freed
    logic chirp_acc;   // new chirp that the write side may accept
    logic last_wr;     // write of the final index of the current bank
    logic restart_w;   // mid-fill chirp restarting the current bank
    logic write_w;     // a sample is written this cycle
    logic free_cur;    // wr_bank_q usable this cycle
    logic free_nxt;    // the other bank usable this cycle

    assign release_w = (rstate_q == R_WAIT) && fft_done_i;
    assign chirp_acc = chirp_start_i && enable_i;
    assign last_wr   = (wstate_q == W_FILL) && sample_valid_i && (wr_idx_q == LAST_IDX);
    assign restart_w = (wstate_q == W_FILL) && chirp_start_i && (wr_idx_q != '0) && !last_wr;
    assign write_w   = (wstate_q == W_FILL) && sample_valid_i && !restart_w;

    // A release in the same cycle makes its bank available to a chirp.
    assign free_cur = !full_q[wr_bank_q]  || (release_w && (rd_bank_q == wr_bank_q));
    assign free_nxt = !full_q[~wr_bank_q] || (release_w && (rd_bank_q != wr_bank_q));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            ctr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            drop_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            ctr_q     <= ctr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
            short_q   <= short_d;
        end
    end

    // -----------------------------------------------------------------------
    // Write FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        wstate_d  = wstate_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        unique case (wstate_q)
            W_IDLE: begin
                if (chirp_acc && free_cur) begin
                    wr_idx_d = '0;
                    wstate_d = W_FILL;
                end
            end
            W_FILL: begin
                if (last_wr) begin
                    // Frame completes; a coincident chirp is judged as if
                    // it arrived in W_IDLE against the other bank.
                    wr_bank_d = ~wr_bank_q;
                    wr_idx_d  = '0;
                    wstate_d  = (chirp_acc && free_nxt) ? W_FILL : W_IDLE;
                end else if (restart_w) begin
                    wr_idx_d = '0;
                end else if (sample_valid_i) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write-side outputs and bank occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        wr_en_d   = write_w;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (write_w) begin
            wr_addr_d = {wr_bank_q, wr_idx_q};
            wr_data_d = sample_i;
        end
        drop_d  = chirp_acc && (((wstate_q == W_IDLE) && !free_cur) || (last_wr && !free_nxt));
        short_d = restart_w;

        // Release and completion always target different banks.
        full_d = full_q;
        if (release_w) full_d[rd_bank_q] = 1'b0;
        if (last_wr)   full_d[wr_bank_q] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Read FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        rstate_d  = rstate_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        ctr_d     = ctr_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) rstate_d = R_START;
            end
            R_START: begin
                rd_idx_d = '0;
                rstate_d = R_READ;
            end
            R_READ: begin
                if (fft_ready_i) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST_IDX) rstate_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (fft_done_i) begin
                    rd_bank_d = ~rd_bank_q;
                    ctr_d     = ctr_q + 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        fft_start_o   = (rstate_q == R_START);
        rd_en_o       = (rstate_q == R_READ) && fft_ready_i;
        rd_addr_o     = {rd_bank_q, rd_idx_q};
        wr_en_o       = wr_en_q;
        wr_addr_o     = wr_addr_q;
        wr_data_o     = wr_data_q;
        frame_drop_o  = drop_q;
        frame_short_o = short_q;
        frame_ctr_o   = ctr_q;
    end

endmodule

// File: tb/tb_fft_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sched
//
// Directed bench for fft_frame_sched with FFT_N = 8. A behavioural model
// tracks bank occupancy, fill progress and read progress as plain integers
// and predicts every output each cycle. A compare process checks the DUT
// against it on the falling edge. Directed scenarios add literal
// expectations on logged write/read address streams, pulse counts and
// latencies.
// ---------------------------------------------------------------------------
module tb_fft_frame_sched;

    localparam int N  = 8;
    localparam int NW = 3;
    localparam int DW = 14;
    localparam int CW = 16;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          en     = 1'b1;
    logic          chirp  = 1'b0;
    logic          sv     = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          ready  = 1'b1;
    logic          done   = 1'b0;

    logic          wr_en_o;
    logic [NW:0]   wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          fft_start_o;
    logic          rd_en_o;
    logic [NW:0]   rd_addr_o;
    logic          frame_drop_o;
    logic          frame_short_o;
    logic [CW-1:0] frame_ctr_o;

    fft_frame_sched #(
        .FFT_N(N),
        .N_WIDTH(NW),
        .DATA_WIDTH(DW),
        .CTR_WIDTH(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .enable_i(en),
        .chirp_start_i(chirp),
        .sample_valid_i(sv),
        .sample_i(sample),
        .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .fft_start_o(fft_start_o),
        .fft_ready_i(ready),
        .rd_en_o(rd_en_o),
        .rd_addr_o(rd_addr_o),
        .fft_done_i(done),
        .frame_drop_o(frame_drop_o),
        .frame_short_o(frame_short_o),
        .frame_ctr_o(frame_ctr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [1:0] m_full;
    int m_filling, m_cnt, m_wb, m_rb, m_rd, m_rcnt, m_ctr;   // m_rd: 0 idle,1 start,2 read,3 wait
    bit e_wr_en, e_drop, e_short;
    int e_wr_addr, e_wr_data;

    function automatic bit bank_free(int b, bit rel);
        return !m_full[b] || (rel && m_rb == b);
    endfunction

    always @(posedge clk) begin : model
        bit [1:0] nf;
        bit rel;
        e_wr_en = 0;
        e_drop  = 0;
        e_short = 0;
        if (rst) begin
            m_full = '0; m_filling = 0; m_cnt = 0; m_wb = 0;
            m_rb = 0; m_rd = 0; m_rcnt = 0; m_ctr = 0;
        end else begin
            rel = (m_rd == 3) && done;
            nf  = m_full;
            if (rel) nf[m_rb] = 1'b0;
            if (m_filling == 0) begin
                if (chirp && en) begin
                    if (bank_free(m_wb, rel)) begin m_filling = 1; m_cnt = 0; end
                    else e_drop = 1;
                end
            end else if (sv && m_cnt == N - 1) begin
                e_wr_en = 1; e_wr_addr = m_wb * N + m_cnt; e_wr_data = int'(sample);
                nf[m_wb] = 1'b1;
                m_wb = 1 - m_wb;
                m_filling = 0;
                if (chirp && en) begin
                    if (bank_free(m_wb, rel)) begin m_filling = 1; m_cnt = 0; end
                    else e_drop = 1;
                end
            end else if (chirp && m_cnt != 0) begin
                e_short = 1;
                m_cnt = 0;
            end else if (sv) begin
                e_wr_en = 1; e_wr_addr = m_wb * N + m_cnt; e_wr_data = int'(sample);
                m_cnt++;
            end
            case (m_rd)
                0: if (m_full[m_rb]) m_rd = 1;
                1: begin m_rd = 2; m_rcnt = 0; end
                2: if (ready) begin
                       if (m_rcnt == N - 1) begin m_rd = 3; m_rcnt = 0; end
                       else m_rcnt++;
                   end
                3: if (done) begin m_rb = 1 - m_rb; m_ctr++; m_rd = 0; end
                default: m_rd = 0;
            endcase
            m_full = nf;
        end
    end

    // ---------------- compare + logging ----------------
    int cyc = 0;
    int wlog[$];
    int dlog[$];
    int rlog[$];
    int n_start = 0, n_drop = 0, n_short = 0;
    int last_wr_cyc = -1, start_cyc = -1, first_rd_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        check("wr_en", wr_en_o, e_wr_en);
        if (e_wr_en) begin
            check("wr_addr", wr_addr_o, e_wr_addr);
            check("wr_data", wr_data_o, e_wr_data);
        end
        check("frame_drop", frame_drop_o, e_drop);
        check("frame_short", frame_short_o, e_short);
        check("fft_start", fft_start_o, m_rd == 1);
        check("rd_en", rd_en_o, (m_rd == 2) && ready);
        if (m_rd == 2 && ready) check("rd_addr", rd_addr_o, m_rb * N + m_rcnt);
        check("frame_ctr", frame_ctr_o, m_ctr);

        if (wr_en_o) begin
            wlog.push_back(int'(wr_addr_o));
            dlog.push_back(int'(wr_data_o));
            last_wr_cyc = cyc;
        end
        if (rd_en_o) begin
            rlog.push_back(int'(rd_addr_o));
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (fft_start_o) begin
            n_start++;
            start_cyc = cyc;
        end
        if (frame_drop_o)  n_drop++;
        if (frame_short_o) n_short++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wlog.delete(); dlog.delete(); rlog.delete();
        n_start = 0; n_drop = 0; n_short = 0;
        last_wr_cyc = -1; start_cyc = -1; first_rd_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; chirp = 1'b0; sv = 1'b0; done = 1'b0; en = 1'b1; ready = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic chirp_pulse();
        chirp = 1'b1;
        tick();
        chirp = 1'b0;
    endtask

    task automatic done_pulse();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic strobes(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            sv = 1'b1;
            sample = DW'(base + i);
            tick();
        end
        sv = 1'b0;
    endtask

    // Compares q[first +: cnt] against base, base+1, ...
    task automatic check_seq(input string name, input int q[$], input int first,
                             input int cnt, input int base);
        for (int i = 0; i < cnt; i++) begin
            if (first + i < q.size()) check(name, q[first + i], base + i);
            else check({name, " missing"}, -1, base + i);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset state
        do_reset();
        check("reset wr_en", wr_en_o, 0);
        check("reset wr_addr", wr_addr_o, 0);
        check("reset wr_data", wr_data_o, 0);
        check("reset fft_start", fft_start_o, 0);
        check("reset rd_en", rd_en_o, 0);
        check("reset rd_addr", rd_addr_o, 0);
        check("reset drop", frame_drop_o, 0);
        check("reset short", frame_short_o, 0);
        check("reset ctr", frame_ctr_o, 0);

        // Basic frame, preceded by a chirp that enable_i blocks
        en = 1'b0;
        chirp_pulse();
        strobes(2, 40);
        en = 1'b1;
        tick(2);
        check("disabled chirp writes", wlog.size(), 0);
        chirp_pulse();
        strobes(8, 0);
        tick(14);
        check("s1 write count", wlog.size(), 8);
        check_seq("s1 wr_addr", wlog, 0, 8, 0);
        check_seq("s1 wr_data", dlog, 0, 8, 0);
        check("s1 start count", n_start, 1);
        check("s1 start latency", start_cyc - last_wr_cyc, 1);
        check("s1 first read latency", first_rd_cyc - start_cyc, 1);
        check("s1 read count", rlog.size(), 8);
        check_seq("s1 rd_addr", rlog, 0, 8, 0);
        check("s1 ctr before done", frame_ctr_o, 0);
        done_pulse();
        check("s1 ctr after done", frame_ctr_o, 1);
        tick(6);
        check("s1 no restart after release", n_start, 1);

        // Both banks full, third chirp dropped
        do_reset();
        chirp_pulse();
        strobes(8, 0);
        chirp_pulse();
        strobes(8, 8);
        tick(4);
        chirp_pulse();
        strobes(3, 60);
        tick(2);
        check("s2 drop count", n_drop, 1);
        check("s2 write count", wlog.size(), 16);
        check_seq("s2 wr_addr", wlog, 0, 16, 0);
        check("s2 reads before release", rlog.size(), 8);
        done_pulse();
        check("s2 ctr", frame_ctr_o, 1);
        tick(14);
        check("s2 reads after release", rlog.size(), 16);
        check_seq("s2 bank1 rd_addr", rlog, 8, 8, 8);
        chirp_pulse();
        strobes(8, 20);
        tick(2);
        check("s2 refill count", wlog.size(), 24);
        check_seq("s2 refill wr_addr", wlog, 16, 8, 0);
        check_seq("s2 refill wr_data", dlog, 16, 8, 20);

        // Short chirp restarts bank 0
        do_reset();
        chirp_pulse();
        strobes(5, 50);
        chirp_pulse();
        strobes(8, 100);
        tick(14);
        check("s3 short count", n_short, 1);
        check("s3 write count", wlog.size(), 13);
        check_seq("s3 wr_addr", wlog, 5, 8, 0);
        check_seq("s3 wr_data", dlog, 5, 8, 100);
        check("s3 start count", n_start, 1);
        check_seq("s3 rd_addr", rlog, 0, 8, 0);

        // Back-pressure during reads
        do_reset();
        ready = 1'b0;
        chirp_pulse();
        strobes(8, 0);
        for (int i = 0; i < 24; i++) begin
            ready = (i % 2 == 0);
            tick();
        end
        ready = 1'b1;
        tick(3);
        check("s4 read count", rlog.size(), 8);
        check_seq("s4 rd_addr", rlog, 0, 8, 0);
        check("s4 start count", n_start, 1);
        done_pulse();
        check("s4 ctr", frame_ctr_o, 1);

        // Reset mid-fill and mid-read
        do_reset();
        chirp_pulse();
        strobes(8, 0);
        tick(12);
        done_pulse();
        check("s5 ctr before reset", frame_ctr_o, 1);
        chirp_pulse();
        strobes(8, 8);
        chirp_pulse();
        strobes(3, 30);
        check("s5 reading before reset", rd_en_o, 1);
        rst = 1'b1;
        sv = 1'b1;
        sample = DW'(33);
        tick();
        rst = 1'b0;
        sv = 1'b0;
        check("s5 post-reset wr_en", wr_en_o, 0);
        check("s5 post-reset wr_addr", wr_addr_o, 0);
        check("s5 post-reset wr_data", wr_data_o, 0);
        check("s5 post-reset fft_start", fft_start_o, 0);
        check("s5 post-reset rd_en", rd_en_o, 0);
        check("s5 post-reset rd_addr", rd_addr_o, 0);
        check("s5 post-reset ctr", frame_ctr_o, 0);
        clear_logs();
        chirp_pulse();
        strobes(8, 70);
        tick(14);
        check_seq("s5 wr_addr", wlog, 0, 8, 0);
        check_seq("s5 wr_data", dlog, 0, 8, 70);
        check("s5 start count", n_start, 1);
        check_seq("s5 rd_addr", rlog, 0, 8, 0);

        // Release of bank 0 coincides with a chirp aimed at bank 0
        do_reset();
        chirp_pulse();
        strobes(8, 0);
        chirp_pulse();
        strobes(8, 8);
        tick(6);
        chirp = 1'b1;
        done  = 1'b1;
        tick();
        chirp = 1'b0;
        done  = 1'b0;
        strobes(8, 90);
        tick(2);
        check("s6 drop count", n_drop, 0);
        check("s6 write count", wlog.size(), 24);
        check_seq("s6 wr_addr", wlog, 16, 8, 0);
        check_seq("s6 wr_data", dlog, 16, 8, 90);
        check("s6 ctr", frame_ctr_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
